// File: rtl/trap_peak_sampler.sv
// Turns each pulse of the signed trapezoid stream into one event record: peak amplitude,
// threshold-crossing timestamp and pile-up flag, delivered through a one-entry valid/ready register.
module trap_peak_sampler #(
  parameter int IN_W    = 24,
  parameter int TS_W    = 32,
  parameter int WIN     = 16,
  parameter int MAX_LEN = 256,
  parameter int HYST    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] threshold,
  output logic signed [IN_W-1:0] ev_amp,
  output logic [TS_W-1:0]        ev_time,
  output logic                   ev_pileup,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [15:0]            lost_cnt,
  output logic                   busy
);

  localparam int CNT_W = $clog2(WIN + 1);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] WIN_V     = CNT_W'(WIN);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PEAK, TAIL, BLOCK} state_t;

  state_t                 state;
  logic [TS_W-1:0]        ts;
  logic [TS_W-1:0]        t0;
  logic signed [IN_W-1:0] max_amp;
  logic [CNT_W-1:0]       cnt;
  logic [LEN_W-1:0]       len;

  logic signed [IN_W:0]   lower;
  logic signed [IN_W:0]   in_ext;
  logic                   trig;
  logic                   fall;
  logic                   emit;
  logic                   emit_pu;
  logic                   out_free;
  logic [CNT_W-1:0]       cnt_inc;
  logic [LEN_W-1:0]       len_inc;

  // One extra bit keeps threshold - HYST from wrapping near the negative limit.
  always_comb begin
    lower    = {threshold[IN_W-1], threshold} - (IN_W+1)'(HYST);
    in_ext   = {in_data[IN_W-1], in_data};
    trig     = in_data > threshold;
    fall     = in_ext <= lower;
    cnt_inc  = cnt + CNT_W'(1);
    len_inc  = len + LEN_W'(1);
    out_free = !ev_valid || ev_ready;
    emit     = 1'b0;
    emit_pu  = 1'b0;
    if (in_valid) begin
      case (state)
        PEAK: emit = fall;
        TAIL: begin
          if (fall) begin
            emit = 1'b1;
          end else if (len_inc == MAX_LEN_V) begin
            emit    = 1'b1;
            emit_pu = 1'b1;
          end else begin
            emit = 1'b0;
          end
        end
        default: emit = 1'b0;
      endcase
    end else begin
      emit = 1'b0;
    end
  end

  // Pulse FSM, timestamp counter and the output record register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ts        <= '0;
      t0        <= '0;
      max_amp   <= '0;
      cnt       <= '0;
      len       <= '0;
      ev_amp    <= '0;
      ev_time   <= '0;
      ev_pileup <= 1'b0;
      ev_valid  <= 1'b0;
      lost_cnt  <= 16'd0;
    end else begin
      if (in_valid) begin
        ts <= ts + TS_W'(1);
        case (state)
          IDLE: begin
            if (trig) begin
              max_amp <= in_data;
              t0      <= ts;
              cnt     <= CNT_W'(1);
              len     <= LEN_W'(1);
              state   <= (WIN == 1) ? TAIL : PEAK;
            end
          end
          PEAK: begin
            if (in_data > max_amp) max_amp <= in_data;
            cnt <= cnt_inc;
            len <= len_inc;
            if (fall) state <= IDLE;
            else if (cnt_inc == WIN_V) state <= TAIL;
          end
          TAIL: begin
            len <= len_inc;
            if (fall) state <= IDLE;
            else if (len_inc == MAX_LEN_V) state <= BLOCK;
          end
          BLOCK: begin
            if (fall) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      // A new record may replace one that is draining on this same edge.
      if (emit) begin
        if (out_free) begin
          ev_amp    <= max_amp;
          ev_time   <= t0;
          ev_pileup <= emit_pu;
          ev_valid  <= 1'b1;
        end else if (lost_cnt != 16'hFFFF) begin
          lost_cnt <= lost_cnt + 16'd1;
        end
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_trap_peak_sampler.sv
// Directed bench for trap_peak_sampler: a vector table for short pulses plus
// hand-written sequences for pile-up, backpressure, reset and timestamp wrap.
module tb_trap_peak_sampler;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [23:0] in_data;
  logic               in_valid;
  logic signed [23:0] threshold;
  logic signed [23:0] ev_amp;
  logic [7:0]         ev_time;
  logic               ev_pileup;
  logic               ev_valid;
  logic               ev_ready;
  logic [15:0]        lost_cnt;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;
  int ts_exp  = 0;

  trap_peak_sampler #(.IN_W(24), .TS_W(8), .WIN(16), .MAX_LEN(256), .HYST(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .threshold(threshold), .ev_amp(ev_amp), .ev_time(ev_time), .ev_pileup(ev_pileup),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .lost_cnt(lost_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   din;
    logic vld;
    logic rdy;
    logic e_v;
    int   e_amp;
    int   e_off;
    logic e_pu;
    logic e_busy;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int d, input logic v);
    in_data  = d[23:0];
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) ts_exp = (ts_exp + 1) % 256;
  endtask

  task automatic check_ev(input string name, input logic v, input int amp, input int t, input logic pu);
    check({name, "_valid"}, {31'd0, ev_valid}, {31'd0, v});
    if (v) begin
      check({name, "_amp"}, ev_amp, amp);
      check({name, "_time"}, {24'd0, ev_time}, t);
      check({name, "_pileup"}, {31'd0, ev_pileup}, {31'd0, pu});
    end
  endtask

  initial begin
    int base;
    int t_ev;
    int extra;

    tbl[0]  = '{0,    1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0};
    tbl[1]  = '{101,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b1};
    tbl[2]  = '{95,   1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b1};
    tbl[3]  = '{0,    1'b0, 1'b1, 1'b0, 0,   0,  1'b0, 1'b1};
    tbl[4]  = '{95,   1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b1};
    tbl[5]  = '{93,   1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b1};
    tbl[6]  = '{92,   1'b1, 1'b1, 1'b1, 101, 1,  1'b0, 1'b0};
    tbl[7]  = '{95,   1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0};
    tbl[8]  = '{0,    1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0};
    tbl[9]  = '{100,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0};
    tbl[10] = '{101,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b1};
    tbl[11] = '{-500, 1'b1, 1'b1, 1'b1, 101, 9,  1'b0, 1'b0};
    tbl[12] = '{300,  1'b1, 1'b0, 1'b1, 101, 9,  1'b0, 1'b1};
    tbl[13] = '{0,    1'b1, 1'b1, 1'b1, 300, 11, 1'b0, 1'b0};
    tbl[14] = '{0,    1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0};

    // Reset state
    reset = 1'b0; in_data = 24'sd0; in_valid = 1'b0; threshold = 24'sd100; ev_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_amp", ev_amp, 32'd0);
    check("rst_time", {24'd0, ev_time}, 32'd0);
    check("rst_lost", {16'd0, lost_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Single triangular pulse at indices 10..30, peak 5000 at 18
    for (int i = 0; i <= 32; i++) begin
      int v;
      if (i < 10 || i > 30) v = 0;
      else if (i <= 18) v = 5000 - (18 - i) * 500;
      else v = 5000 - (i - 18) * 400;
      step(v, 1'b1);
      if (i == 30) begin
        check_ev("single_pre", 1'b0, 0, 0, 1'b0);
        check("single_busy", {31'd0, busy}, 32'd1);
      end
      if (i == 31) check_ev("single", 1'b1, 5000, 10, 1'b0);
      if (i == 32) check_ev("single_drop", 1'b0, 0, 0, 1'b0);
    end

    // Table: hysteresis, gap, equality threshold, short pulse, back-to-back records
    base = ts_exp;
    for (int i = 0; i < 15; i++) begin
      ev_ready = tbl[i].rdy;
      step(tbl[i].din, tbl[i].vld);
      check_ev($sformatf("tbl%0d", i), tbl[i].e_v, tbl[i].e_amp, (base + tbl[i].e_off) % 256, tbl[i].e_pu);
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
    end
    check("tbl_lost", {16'd0, lost_cnt}, 32'd0);

    // Pile-up: 300 samples at 2000
    ev_ready = 1'b1;
    t_ev = ts_exp;
    extra = 0;
    for (int k = 0; k < 300; k++) begin
      step(2000, 1'b1);
      if (k == 254) check_ev("pu_pre", 1'b0, 0, 0, 1'b0);
      if (k == 255) begin
        check_ev("pu", 1'b1, 2000, t_ev, 1'b1);
        check("pu_busy", {31'd0, busy}, 32'd1);
      end
      if (k > 255 && ev_valid) extra++;
    end
    check("pu_extra_events", extra, 32'd0);
    check("pu_block_busy", {31'd0, busy}, 32'd1);
    step(0, 1'b1);
    check("pu_exit_busy", {31'd0, busy}, 32'd0);
    t_ev = ts_exp;
    step(500, 1'b1);
    step(600, 1'b1);
    step(0, 1'b1);
    check_ev("pu_clean", 1'b1, 600, t_ev, 1'b0);
    step(0, 1'b1);

    // Backpressure: three pulses while ev_ready=0
    ev_ready = 1'b0;
    t_ev = ts_exp;
    for (int p = 0; p < 3; p++) begin
      step(1000 + 100 * p, 1'b1);
      step(0, 1'b1);
      check_ev($sformatf("bp%0d", p), 1'b1, 1000, t_ev, 1'b0);
      check($sformatf("bp%0d_lost", p), {16'd0, lost_cnt}, p);
    end
    ev_ready = 1'b1;
    step(0, 1'b0);
    check_ev("bp_drain", 1'b0, 0, 0, 1'b0);
    check("bp_lost_final", {16'd0, lost_cnt}, 32'd2);

    // Reset in the middle of PEAK
    step(0, 1'b1);
    step(700, 1'b1);
    step(800, 1'b1);
    check("rm_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    in_data = 24'sd900; in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ts_exp = 0;
    check("rm_valid", {31'd0, ev_valid}, 32'd0);
    check("rm_amp", ev_amp, 32'd0);
    check("rm_time", {24'd0, ev_time}, 32'd0);
    check("rm_pileup", {31'd0, ev_pileup}, 32'd0);
    check("rm_lost", {16'd0, lost_cnt}, 32'd0);
    check("rm_busy0", {31'd0, busy}, 32'd0);
    step(0, 1'b1);
    step(0, 1'b1);
    step(300, 1'b1);
    step(0, 1'b1);
    check_ev("rm_next", 1'b1, 300, 2, 1'b0);
    step(0, 1'b1);

    // Gaps and timestamp wrap: reach ts=250 with in_valid toggling
    while (ts_exp != 250) begin
      step(0, 1'b1);
      step(0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 1'b1);
      step(0, 1'b0);
    end
    step(400, 1'b1);
    step(0, 1'b0);
    step(400, 1'b0);
    check("gap_busy", {31'd0, busy}, 32'd1);
    check_ev("gap_pre", 1'b0, 0, 0, 1'b0);
    step(0, 1'b1);
    check_ev("gap_ev", 1'b1, 400, 254, 1'b0);
    step(0, 1'b0);
    check_ev("gap_drain", 1'b0, 0, 0, 1'b0);
    step(500, 1'b1);
    step(0, 1'b0);
    step(0, 1'b1);
    check_ev("wrap_ev", 1'b1, 500, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
